// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two byte-enabled write ports (port 1 wins per byte), optional bypass and zero r0.
// Writes land on one clk edge; reads are 0-cycle; the write ports are always ready (no backpressure).
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NRD*ADDR_W-1:0]  raddr,
  output logic [NRD*DATA_W-1:0]  rdata,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      waddr0,
  input  logic [DATA_W/8-1:0]    wbe0,
  input  logic [DATA_W-1:0]      wdata0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      waddr1,
  input  logic [DATA_W/8-1:0]    wbe1,
  input  logic [DATA_W-1:0]      wdata1
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  logic [DATA_W-1:0] w_mem [DEPTH];

  genvar w;
  generate
    for (w = 0; w < DEPTH; w++) begin : g_word
      localparam bit WR_OK = !((ZERO_R0 != 0) && (w == 0));
      logic [DATA_W-1:0] r_word;
      logic              w_hit0;
      logic              w_hit1;

      assign w_hit0 = WR_OK && we0 && (waddr0 == ADDR_W'(w));
      assign w_hit1 = WR_OK && we1 && (waddr1 == ADDR_W'(w));

      // "resetn" is active-high despite its name.
      always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
          r_word <= '0;
        end else begin
          for (int b = 0; b < NB; b++) begin
            if (w_hit1 && wbe1[b])
              r_word[b*8 +: 8] <= wdata1[b*8 +: 8];
            else if (w_hit0 && wbe0[b])
              r_word[b*8 +: 8] <= wdata0[b*8 +: 8];
          end
        end
      end

      assign w_mem[w] = r_word;
    end
  endgenerate

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = raddr[k*ADDR_W +: ADDR_W];

      // Bypass mirrors the write merge so a partial write reads back merged with old contents.
      always_comb begin
        w_rd = w_mem[w_ra];
        if ((BYPASS != 0) && !resetn) begin
          for (int b = 0; b < NB; b++) begin
            if (we1 && (waddr1 == w_ra) && wbe1[b])
              w_rd[b*8 +: 8] = wdata1[b*8 +: 8];
            else if (we0 && (waddr0 == w_ra) && wbe0[b])
              w_rd[b*8 +: 8] = wdata0[b*8 +: 8];
          end
        end
        if ((ZERO_R0 != 0) && (w_ra == '0))
          w_rd = '0;
      end

      assign rdata[k*DATA_W +: DATA_W] = w_rd;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (no bypass/zero r0, bypass/zero r0, no bypass/plain r0) share one stimulus.
`timescale 1ns/1ps
module tb_regfile_mp;

  logic        clk;
  logic        resetn;
  logic [9:0]  raddr;
  logic [63:0] rd_a, rd_b, rd_c;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [3:0]  wbe0, wbe1;
  logic [31:0] wdata0, wdata1;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_R0(1)) u_a (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rd_a),
    .we0(we0), .waddr0(waddr0), .wbe0(wbe0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wbe1(wbe1), .wdata1(wdata1));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_R0(1)) u_b (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rd_b),
    .we0(we0), .waddr0(waddr0), .wbe0(wbe0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wbe1(wbe1), .wdata1(wdata1));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_R0(0)) u_c (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rd_c),
    .we0(we0), .waddr0(waddr0), .wbe0(wbe0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wbe1(wbe1), .wdata1(wdata1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ea0, ea1, eb0, eb1, ec0, ec1;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1,
                         input logic [31:0] ec0, input logic [31:0] ec1);
    chk({tag, " A0"}, rd_a[31:0],  ea0);
    chk({tag, " A1"}, rd_a[63:32], ea1);
    chk({tag, " B0"}, rd_b[31:0],  eb0);
    chk({tag, " B1"}, rd_b[63:32], eb1);
    chk({tag, " C0"}, rd_c[31:0],  ec0);
    chk({tag, " C1"}, rd_c[63:32], ec1);
  endtask

  task automatic idle_writes();
    we0 = 1'b0; waddr0 = '0; wbe0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wbe1 = '0; wdata1 = '0;
  endtask

  initial begin
    // Pre-edge expectations: A/C show stored contents, B shows the bypassed merge.
    vecs[0]  = '{1'b1, 5'd5,  4'hF, 32'h00000001, 1'b0, 5'd0,  4'h0, 32'h0,
                 5'd5,  5'd6,  32'h0, 32'h0, 32'h00000001, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 5'd6,  4'hF, 32'h00000010, 1'b0, 5'd0,  4'h0, 32'h0,
                 5'd5,  5'd6,  32'h1, 32'h0, 32'h1, 32'h10, 32'h1, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 5'd0,  4'h0, 32'h0,
                 5'd6,  5'd5,  32'h10, 32'h1, 32'h10, 32'h1, 32'h10, 32'h1};
    vecs[3]  = '{1'b1, 5'd3,  4'hF, 32'h11223344, 1'b0, 5'd0,  4'h0, 32'h0,
                 5'd3,  5'd8,  32'h0, 32'h0, 32'h11223344, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd3,  4'b0101, 32'hAABBCCDD, 1'b0, 5'd0, 4'h0, 32'h0,
                 5'd3,  5'd5,  32'h11223344, 32'h1, 32'h11BB33DD, 32'h1, 32'h11223344, 32'h1};
    vecs[5]  = '{1'b1, 5'd9,  4'hF, 32'h0000FFFF, 1'b1, 5'd9,  4'b1100, 32'hABCD0000,
                 5'd9,  5'd3,  32'h0, 32'h11BB33DD, 32'hABCDFFFF, 32'h11BB33DD, 32'h0, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 5'd0,  4'h0, 32'h0,
                 5'd9,  5'd9,  32'hABCDFFFF, 32'hABCDFFFF, 32'hABCDFFFF, 32'hABCDFFFF, 32'hABCDFFFF, 32'hABCDFFFF};
    vecs[7]  = '{1'b1, 5'd10, 4'b0011, 32'h11111111, 1'b1, 5'd10, 4'b0110, 32'h22222222,
                 5'd10, 5'd9,  32'h0, 32'hABCDFFFF, 32'h00222211, 32'hABCDFFFF, 32'h0, 32'hABCDFFFF};
    vecs[8]  = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b1, 5'd4,  4'hF, 32'h00000005,
                 5'd10, 5'd4,  32'h00222211, 32'h0, 32'h00222211, 32'h5, 32'h00222211, 32'h0};
    vecs[9]  = '{1'b1, 5'd4,  4'b0001, 32'h000000AA, 1'b0, 5'd0, 4'h0, 32'h0,
                 5'd4,  5'd8,  32'h5, 32'h0, 32'hAA, 32'h0, 32'h5, 32'h0};
    vecs[10] = '{1'b1, 5'd0,  4'hF, 32'hFFFFFFFF, 1'b1, 5'd0,  4'hF, 32'hFFFFFFFF,
                 5'd0,  5'd4,  32'h0, 32'hAA, 32'h0, 32'hAA, 32'h0, 32'hAA};
    vecs[11] = '{1'b1, 5'd4,  4'h0, 32'hFFFFFFFF, 1'b0, 5'd0,  4'h0, 32'h0,
                 5'd0,  5'd4,  32'h0, 32'hAA, 32'h0, 32'hAA, 32'hFFFFFFFF, 32'hAA};
    vecs[12] = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 5'd0,  4'h0, 32'h0,
                 5'd4,  5'd0,  32'hAA, 32'h0, 32'hAA, 32'h0, 32'hAA, 32'hFFFFFFFF};
    vecs[13] = '{1'b1, 5'd1,  4'hF, 32'h01010101, 1'b1, 5'd2,  4'hF, 32'h02020202,
                 5'd1,  5'd2,  32'h0, 32'h0, 32'h01010101, 32'h02020202, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 5'd0,  4'h0, 32'h0,
                 5'd2,  5'd1,  32'h02020202, 32'h01010101, 32'h02020202, 32'h01010101, 32'h02020202, 32'h01010101};

    resetn = 1'b1;
    idle_writes();
    raddr = {5'd1, 5'd5};
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    resetn = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wbe0 = vecs[i].be0; wdata0 = vecs[i].wd0;
      we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wbe1 = vecs[i].be1; wdata1 = vecs[i].wd1;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].ea0, vecs[i].ea1, vecs[i].eb0,
              vecs[i].eb1, vecs[i].ec0, vecs[i].ec1);
      @(posedge clk); #1;
    end

    // Async reset pulse mid-cycle clears a written word immediately.
    idle_writes();
    we0 = 1'b1; waddr0 = 5'd7; wbe0 = 4'hF; wdata0 = 32'hDEADBEEF;
    raddr = {5'd9, 5'd7};
    @(posedge clk); #1;
    idle_writes();
    #1;
    chk_all("r7 written", 32'hDEADBEEF, 32'hABCDFFFF, 32'hDEADBEEF, 32'hABCDFFFF,
            32'hDEADBEEF, 32'hABCDFFFF);
    #1;
    resetn = 1'b1;
    #0.5;
    chk_all("rst pulse", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #0.5;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_all("post pulse", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Write held across an edge during reset is lost; bypass is suppressed.
    raddr = {5'd2, 5'd7};
    we0 = 1'b1; waddr0 = 5'd7; wbe0 = 4'hF; wdata0 = 32'h12345678;
    we1 = 1'b1; waddr1 = 5'd2; wbe1 = 4'hF; wdata1 = 32'h87654321;
    resetn = 1'b1;
    #1;
    chk_all("rst+we", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b0;
    idle_writes();
    #1;
    chk_all("rst lost", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // First edge after release accepts a write.
    we0 = 1'b1; waddr0 = 5'd7; wbe0 = 4'b1000; wdata0 = 32'h5A000000;
    @(posedge clk); #1;
    idle_writes();
    #1;
    chk_all("first wr", 32'h5A000000, 32'h0, 32'h5A000000, 32'h0, 32'h5A000000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the openMIPS core, and the successor to the current two-read/one-write `REG` block. It provides `NRD` combinational read ports and two clocked write ports with byte enables. It also offers an optional same-cycle write-to-read bypass and an optionally hard-wired zero register. It sits between decode (read addresses), writeback (write port 0) and the load/multi-cycle unit (write port 1).

## Interface
Parameters:
- `DATA_W`, 32, register width in bits; must be a multiple of 8.
- `ADDR_W`, 5, address width; depth is `2**ADDR_W`.
- `NRD`, 2, number of read ports (1..4).
- `BYPASS`, 1, 1 = a read of an address being written this cycle returns the merged write data; 0 = the read returns stored contents.
- `ZERO_R0`, 1, 1 = register 0 reads 0 and ignores writes.

Ports:
- `clk`  in  1  clock; all writes occur on its rising edge.
- `resetn`  in  1  asynchronous, active-high reset. Despite the legacy name, 1 = reset asserted.
- `raddr`  in  `NRD*ADDR_W`  read addresses; port k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `rdata`  out  `NRD*DATA_W`  read data; port k occupies bits `[k*DATA_W +: DATA_W]`.
- `we0`  in  1  write enable, port 0.
- `waddr0`  in  `ADDR_W`  write address, port 0.
- `wbe0`  in  `DATA_W/8`  byte enables, port 0.
- `wdata0`  in  `DATA_W`  write data, port 0.
- `we1`, `waddr1`, `wbe1`, `wdata1`  same widths and meaning as port 0, for port 1.

## Operation
- Storage: `2**ADDR_W` words of `DATA_W` bits.
- Reset: while `resetn`=1, every word is cleared to 0 asynchronously, and writes are blocked. `rdata` therefore reads 0 on all ports during reset and after it, until the first write.
- Write: at a rising `clk` edge with `resetn`=0 and `weN`=1, byte i of `waddrN` takes `wdataN` byte i wherever `wbeN[i]`=1. Bytes with enable 0 keep their value. `weN`=1 with `wbeN`=0 has no effect.
- Write collision: when both ports are enabled and `waddr0`==`waddr1`, the merge is done per byte. Port 1 wins on bytes where `wbe1` is set, port 0 supplies bytes enabled only in `wbe0`, and all other bytes are unchanged.
- Zero register: when `ZERO_R0`=1, writes to address 0 are dropped and reads of address 0 return 0. This applies in bypass mode too.
- Read: purely combinational from `raddr`. Every port is independent, and any number of ports may read the same address.
- Bypass (`BYPASS`=1): if some `weN`=1 and `waddrN`==`raddr[k]`, `rdata[k]` returns the post-edge value. That value is the stored word with the same per-byte merge and priority as the write, so partial-byte writes are merged with old contents. During reset, bypass is suppressed and reads return 0.
- Bypass off (`BYPASS`=0): `rdata[k]` changes only after the clock edge that commits the write.

## Timing
- Write latency is one edge. Data is visible to reads from the cycle after the edge (`BYPASS`=0), or in the same cycle (`BYPASS`=1).
- Read latency is 0 cycles. It is a combinational path from `raddr`, `we*`, `waddr*`, `wbe*` and `wdata*` to `rdata`, with the last four contributing only when `BYPASS`=1.
- Reset assertion clears `rdata` without waiting for `clk`. Deassertion is assumed to be synchronised upstream, and the first write is accepted on the first edge with `resetn`=0.
- Reset mid-write: if `resetn` rises in a cycle where `we`=1, the write is lost and the word is 0.
- No handshake exists; the write ports are always ready.

## Test plan
- Reset clear: write `32'hDEADBEEF` to r7, pulse `resetn`=1 for 1 ns mid-cycle -> `rdata` for r7 = 0 immediately and after the next edge.
- Basic write/read (`BYPASS`=0): `we0`=1, `waddr0`=5, `wbe0`=4'hF, `wdata0`=32'h1, read r5 on port 0 -> port 0 reads 0 before the edge and 32'h1 after it. Then write r6=32'h10 and read r6 on port 1 -> 32'h10 after the edge, with r5 still 32'h1.
- Byte enables: r3=32'h11223344, then write `wbe0`=4'b0101, `wdata0`=32'hAABBCCDD -> r3 = 32'h11BB33DD.
- Dual-write collision: same cycle, port 0 writes r9 `wbe`=4'hF data 32'h0000FFFF and port 1 writes r9 `wbe`=4'b1100 data 32'hABCD0000 -> r9 = 32'hABCDFFFF.
- Bypass (`BYPASS`=1): r4=32'h5, write r4 with `wbe`=4'b0001 data 32'h000000AA and read r4 in the same cycle -> `rdata`=32'h000000AA before the edge. A read of r8 in the same cycle is unaffected.
- Zero register: with `ZERO_R0`=1, write r0=32'hFFFFFFFF on both ports -> r0 reads 0 in the same cycle and after the edge. Repeat with `ZERO_R0`=0 -> r0 reads 32'hFFFFFFFF after the edge.
